// File: rtl/ps2_led_cmd_sequencer.sv
// PS/2 host-to-keyboard "Set LEDs" sequencer: sends 0xED + LED byte, consumes FA/FE replies
// with a shared retry budget and ACK timeout, and forwards every other received byte.
`timescale 1ns/1ps

module ps2_led_cmd_sequencer #(
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       LED_REQ,
  input  logic [2:0] LED_VAL,
  output logic       LED_BUSY,
  output logic       LED_DONE,
  output logic       LED_ERR,
  output logic [7:0] TX_DATA,
  output logic       TX_START,
  input  logic       TX_READY,
  input  logic       TX_DONE,
  input  logic [7:0] RX_DATA,
  input  logic       RX_VALID,
  output logic [7:0] KEY_DATA,
  output logic       KEY_VALID
);

  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [7:0]    CMD_SET_LED = 8'hED;
  localparam logic [7:0]    RSP_ACK     = 8'hFA;
  localparam logic [7:0]    RSP_RESEND  = 8'hFE;
  localparam logic [TW-1:0] TOUT_LAST   = TW'(TIMEOUT_CYC - 1);
  localparam logic [RW-1:0] RETRY_LAST  = RW'(MAX_RETRY);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_SEND_CMD  = 4'd1,
    ST_WAIT_CMD_TX = 4'd2,
    ST_WAIT_ACK1 = 4'd3,
    ST_SEND_ARG  = 4'd4,
    ST_WAIT_ARG_TX = 4'd5,
    ST_WAIT_ACK2 = 4'd6,
    ST_DONE      = 4'd7,
    ST_ERR       = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [7:0]    led_byte_q, led_byte_d;
  logic          pend_q, pend_d;
  logic [2:0]    pend_val_q, pend_val_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [TW-1:0] tout_q, tout_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_start_q, tx_start_d;
  logic [7:0]    key_data_q, key_data_d;
  logic          key_valid_q, key_valid_d;

  logic in_wait_ack;
  logic in_wait_tx;
  logic rx_ack;
  logic rx_resend;
  logic timeout;
  logic nak;
  logic retry_left;
  logic start_txn;

  assign in_wait_ack = (state_q == ST_WAIT_ACK1) || (state_q == ST_WAIT_ACK2);
  assign in_wait_tx  = (state_q == ST_WAIT_CMD_TX) || (state_q == ST_WAIT_ARG_TX);
  assign rx_ack      = RX_VALID && (RX_DATA == RSP_ACK);
  assign rx_resend   = RX_VALID && (RX_DATA == RSP_RESEND);
  assign timeout     = in_wait_ack && (tout_q == TOUT_LAST);
  // An ACK arriving in the timeout cycle still advances the transaction
  assign nak         = in_wait_ack && !rx_ack && (rx_resend || timeout);
  assign retry_left  = (retry_q != RETRY_LAST);
  assign start_txn   = (state_q == ST_IDLE) && (LED_REQ || pend_q);

  // State register
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:        if (start_txn) state_d = ST_SEND_CMD;
      ST_SEND_CMD:    if (TX_READY) state_d = ST_WAIT_CMD_TX;
      ST_WAIT_CMD_TX: if (TX_DONE) state_d = ST_WAIT_ACK1;
      ST_WAIT_ACK1: begin
        if (rx_ack)   state_d = ST_SEND_ARG;
        else if (nak) state_d = retry_left ? ST_SEND_CMD : ST_ERR;
      end
      ST_SEND_ARG:    if (TX_READY) state_d = ST_WAIT_ARG_TX;
      ST_WAIT_ARG_TX: if (TX_DONE) state_d = ST_WAIT_ACK2;
      ST_WAIT_ACK2: begin
        if (rx_ack)   state_d = ST_DONE;
        else if (nak) state_d = retry_left ? ST_SEND_ARG : ST_ERR;
      end
      ST_DONE:        state_d = ST_IDLE;
      ST_ERR:         state_d = ST_IDLE;
      default:        state_d = ST_IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    led_byte_d  = led_byte_q;
    pend_d      = pend_q;
    pend_val_d  = pend_val_q;
    retry_d     = retry_q;
    tout_d      = tout_q;
    tx_data_d   = tx_data_q;
    tx_start_d  = 1'b0;
    key_data_d  = key_data_q;
    key_valid_d = 1'b0;

    if (state_q == ST_IDLE) begin
      pend_d = 1'b0;
      if (start_txn) begin
        led_byte_d = LED_REQ ? {5'b0, LED_VAL} : {5'b0, pend_val_q};
        retry_d    = '0;
      end
    end else if (LED_REQ) begin
      // Single-entry buffer: the newest request while busy replaces any older one
      pend_d     = 1'b1;
      pend_val_d = LED_VAL;
    end

    if ((state_q == ST_SEND_CMD) && TX_READY) begin
      tx_start_d = 1'b1;
      tx_data_d  = CMD_SET_LED;
    end else if ((state_q == ST_SEND_ARG) && TX_READY) begin
      tx_start_d = 1'b1;
      tx_data_d  = led_byte_q;
    end

    if (in_wait_tx && TX_DONE) begin
      tout_d = '0;
    end else if (in_wait_ack && (tout_q != TOUT_LAST)) begin
      tout_d = tout_q + TW'(1);
    end

    if (nak && retry_left) begin
      retry_d = retry_q + RW'(1);
    end

    if (RX_VALID) begin
      key_data_d = RX_DATA;
      key_valid_d = !(in_wait_ack && (rx_ack || rx_resend));
    end
  end

  // Status pulses track the state being entered so they line up with DONE/ERR
  always_comb begin
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
    err_d  = (state_d == ST_ERR);
  end

  // Datapath and output registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      led_byte_q  <= '0;
      pend_q      <= 1'b0;
      pend_val_q  <= '0;
      retry_q     <= '0;
      tout_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      tx_data_q   <= '0;
      tx_start_q  <= 1'b0;
      key_data_q  <= '0;
      key_valid_q <= 1'b0;
    end else begin
      led_byte_q  <= led_byte_d;
      pend_q      <= pend_d;
      pend_val_q  <= pend_val_d;
      retry_q     <= retry_d;
      tout_q      <= tout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
      tx_data_q   <= tx_data_d;
      tx_start_q  <= tx_start_d;
      key_data_q  <= key_data_d;
      key_valid_q <= key_valid_d;
    end
  end

  assign LED_BUSY  = busy_q;
  assign LED_DONE  = done_q;
  assign LED_ERR   = err_q;
  assign TX_DATA   = tx_data_q;
  assign TX_START  = tx_start_q;
  assign KEY_DATA  = key_data_q;
  assign KEY_VALID = key_valid_q;

endmodule

// File: tb/tb_ps2_led_cmd_sequencer.sv
// Scoreboard bench for ps2_led_cmd_sequencer: a PS/2 TX/keyboard model replies per a plan,
// a monitor pops expected TX bytes and forwarded keys as the DUT emits them.
`timescale 1ns/1ps

module tb_ps2_led_cmd_sequencer;
  localparam int unsigned TOC = 100;
  localparam int unsigned MR  = 3;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       LED_REQ;
  logic [2:0] LED_VAL;
  logic       LED_BUSY, LED_DONE, LED_ERR;
  logic [7:0] TX_DATA;
  logic       TX_START;
  logic       TX_READY, TX_DONE;
  logic [7:0] RX_DATA;
  logic       RX_VALID;
  logic [7:0] KEY_DATA;
  logic       KEY_VALID;

  ps2_led_cmd_sequencer #(.TIMEOUT_CYC(TOC), .MAX_RETRY(MR)) dut (
    .CLK(CLK), .RST_N(RST_N), .LED_REQ(LED_REQ), .LED_VAL(LED_VAL),
    .LED_BUSY(LED_BUSY), .LED_DONE(LED_DONE), .LED_ERR(LED_ERR),
    .TX_DATA(TX_DATA), .TX_START(TX_START), .TX_READY(TX_READY), .TX_DONE(TX_DONE),
    .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .KEY_DATA(KEY_DATA), .KEY_VALID(KEY_VALID)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         n;
    logic [7:0] b0;
    logic [7:0] b1;
    int         dly;
  } reply_t;

  reply_t     plan[$];
  logic [7:0] exp_tx[$];
  logic [7:0] exp_key[$];
  int         tx_cyc[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  int         done_cnt = 0;
  int         err_cnt = 0;
  int         key_cnt = 0;
  int         inj_seq = 0;
  logic [7:0] inj_byte = 8'h00;

  function automatic reply_t mk(int n, logic [7:0] b0, logic [7:0] b1, int dly);
    reply_t r;
    r.n = n; r.b0 = b0; r.b1 = b1; r.dly = dly;
    return r;
  endfunction

  // PS/2 transmitter + keyboard model
  initial begin
    int         tx_cnt;
    int         gap;
    int         served;
    logic [7:0] rxq[$];
    reply_t     r;
    tx_cnt = 0; gap = 0; served = 0;
    TX_READY = 1'b1; TX_DONE = 1'b0; RX_VALID = 1'b0; RX_DATA = 8'h00;
    forever begin
      @(negedge CLK);
      TX_DONE = 1'b0;
      RX_VALID = 1'b0;
      if (TX_START) begin
        TX_READY = 1'b0;
        tx_cnt = 3;
      end else if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          TX_DONE = 1'b1;
          TX_READY = 1'b1;
          if (plan.size() > 0) begin
            r = plan.pop_front();
            if (r.n > 0) rxq.push_back(r.b0);
            if (r.n > 1) rxq.push_back(r.b1);
            gap = r.dly;
          end
        end
      end
      if (inj_seq != served) begin
        served++;
        RX_DATA = inj_byte;
        RX_VALID = 1'b1;
      end else if (rxq.size() > 0 && !TX_DONE) begin
        if (gap == 0) begin
          RX_DATA = rxq.pop_front();
          RX_VALID = 1'b1;
          gap = 1;
        end else begin
          gap--;
        end
      end
    end
  end

  // Monitor: scoreboard pops on every DUT output event
  initial begin
    logic [7:0] e;
    logic [7:0] last_tx;
    last_tx = 8'h00;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (TX_START === 1'b1) begin
        n_cmp++;
        tx_cyc.push_back(cyc);
        if (exp_tx.size() == 0) begin
          n_bad++;
          $display("FAIL tx_unexpected: TX_START with TX_DATA=%h, required none", TX_DATA);
          last_tx = TX_DATA;
        end else begin
          e = exp_tx.pop_front();
          last_tx = e;
          if (TX_DATA !== e) begin
            n_bad++;
            $display("FAIL tx_data: got %h, required %h", TX_DATA, e);
          end
        end
      end else if (RST_N === 1'b1) begin
        n_cmp++;
        if (TX_DATA !== last_tx) begin
          n_bad++;
          $display("FAIL tx_data_hold: got %h, required %h", TX_DATA, last_tx);
        end
      end else begin
        last_tx = 8'h00;
      end
      if (KEY_VALID === 1'b1) begin
        n_cmp++;
        key_cnt++;
        if (exp_key.size() == 0) begin
          n_bad++;
          $display("FAIL key_unexpected: KEY_DATA=%h, required no KEY_VALID", KEY_DATA);
        end else begin
          e = exp_key.pop_front();
          if (KEY_DATA !== e) begin
            n_bad++;
            $display("FAIL key_data: got %h, required %h", KEY_DATA, e);
          end
        end
      end
      if (LED_DONE === 1'b1) begin
        done_cnt++;
        n_cmp++;
        if (!(RX_VALID === 1'b1 && RX_DATA === 8'hFA) || LED_ERR === 1'b1) begin
          n_bad++;
          $display("FAIL done_timing: LED_DONE without FA in previous cycle (rx_valid=%b rx=%h err=%b)",
                   RX_VALID, RX_DATA, LED_ERR);
        end
      end
      if (LED_ERR === 1'b1) err_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic request(input logic [2:0] v);
    @(negedge CLK);
    LED_REQ = 1'b1;
    LED_VAL = v;
    @(negedge CLK);
    LED_REQ = 1'b0;
  endtask

  task automatic inject(input logic [7:0] b);
    @(posedge CLK);
    inj_byte = b;
    inj_seq++;
    cycles(3);
  endtask

  task automatic wait_quiet(input int budget, output bit ok);
    int k;
    k = 0;
    while (k < budget && (LED_BUSY !== 1'b0 || exp_tx.size() != 0 || plan.size() != 0)) begin
      @(negedge CLK);
      k++;
    end
    ok = (k < budget);
    cycles(8);
  endtask

  task automatic test_reset();
    RST_N = 1'b0; LED_REQ = 1'b0; LED_VAL = 3'b000;
    cycles(3);
    n_cmp++;
    if ({LED_BUSY, LED_DONE, LED_ERR, TX_START, TX_DATA, KEY_VALID, KEY_DATA} !== 21'h0) begin
      n_bad++;
      $display("FAIL reset_outputs: got busy=%b done=%b err=%b txs=%b txd=%h kv=%b kd=%h, required all 0",
               LED_BUSY, LED_DONE, LED_ERR, TX_START, TX_DATA, KEY_VALID, KEY_DATA);
    end
    RST_N = 1'b1;
    cycles(2);
  endtask

  task automatic test_nominal();
    int d0, e0, k0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt; k0 = key_cnt;
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h05);
    plan.push_back(mk(1, 8'hFA, 8'h00, 1)); plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    request(3'b101);
    n_cmp++;
    if (LED_BUSY !== 1'b1) begin n_bad++; $display("FAIL nominal_busy: got %b, required 1", LED_BUSY); end
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL nominal_timeout: transaction did not finish, required finish"); end
    n_cmp++;
    if (done_cnt - d0 != 1 || err_cnt - e0 != 0 || key_cnt - k0 != 0) begin
      n_bad++;
      $display("FAIL nominal_counts: done=%0d err=%0d keys=%0d, required 1/0/0",
               done_cnt - d0, err_cnt - e0, key_cnt - k0);
    end
  endtask

  task automatic test_resend();
    int d0, e0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_tx.push_back(8'hED); exp_tx.push_back(8'hED); exp_tx.push_back(8'h05);
    plan.push_back(mk(1, 8'hFE, 8'h00, 1));
    plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    request(3'b101);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_bad++;
      $display("FAIL resend: ok=%b done=%0d err=%0d, required 1/1/0", ok, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_timeout();
    int d0, e0, t0, dt;
    bit ok;
    d0 = done_cnt; e0 = err_cnt; t0 = tx_cyc.size();
    for (int i = 0; i < 4; i++) begin
      exp_tx.push_back(8'hED);
      plan.push_back(mk(0, 8'h00, 8'h00, 1));
    end
    request(3'b111);
    wait_quiet(2000, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      n_bad++;
      $display("FAIL timeout_err: ok=%b done=%0d err=%0d, required 1/0/1", ok, done_cnt - d0, err_cnt - e0);
    end
    n_cmp++;
    if (tx_cyc.size() - t0 != 4) begin
      n_bad++;
      $display("FAIL timeout_tx_count: got %0d, required 4", tx_cyc.size() - t0);
    end else begin
      for (int i = t0 + 1; i < t0 + 4; i++) begin
        dt = tx_cyc[i] - tx_cyc[i-1];
        n_cmp++;
        if (dt < 100 || dt > 110) begin
          n_bad++;
          $display("FAIL timeout_spacing: got %0d cycles, required 100..110", dt);
        end
      end
    end
    n_cmp++;
    if (LED_BUSY !== 1'b0) begin n_bad++; $display("FAIL timeout_busy: got %b, required 0", LED_BUSY); end
  endtask

  task automatic test_interleave();
    int d0;
    bit ok;
    d0 = done_cnt;
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h03);
    exp_key.push_back(8'h1C);
    plan.push_back(mk(2, 8'h1C, 8'hFA, 1));
    plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    request(3'b011);
    wait_quiet(500, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 1 || exp_key.size() != 0) begin
      n_bad++;
      $display("FAIL interleave: ok=%b done=%0d keys_left=%0d, required 1/1/0", ok, done_cnt - d0, exp_key.size());
    end
  endtask

  task automatic test_pending();
    int d0;
    bit ok;
    d0 = done_cnt;
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h06);
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h02);
    for (int i = 0; i < 4; i++) plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    request(3'b110);
    cycles(2);
    request(3'b001);
    cycles(1);
    request(3'b010);
    wait_quiet(800, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 2 || exp_tx.size() != 0) begin
      n_bad++;
      $display("FAIL pending: ok=%b done=%0d tx_left=%0d, required 1/2/0", ok, done_cnt - d0, exp_tx.size());
    end
  endtask

  task automatic test_retry_shared();
    int d0, e0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_tx.push_back(8'hED); exp_tx.push_back(8'hED);
    exp_tx.push_back(8'h04); exp_tx.push_back(8'h04); exp_tx.push_back(8'h04);
    plan.push_back(mk(1, 8'hFE, 8'h00, 1));
    plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    for (int i = 0; i < 3; i++) plan.push_back(mk(1, 8'hFE, 8'h00, 1));
    request(3'b100);
    wait_quiet(800, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 0 || err_cnt - e0 != 1) begin
      n_bad++;
      $display("FAIL retry_shared: ok=%b done=%0d err=%0d, required 1/0/1", ok, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_ack_vs_timeout();
    int d0, e0;
    bit ok;
    d0 = done_cnt; e0 = err_cnt;
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h01);
    plan.push_back(mk(1, 8'hFA, 8'h00, 99));
    plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    request(3'b001);
    wait_quiet(800, ok);
    n_cmp++;
    if (!ok || done_cnt - d0 != 1 || err_cnt - e0 != 0) begin
      n_bad++;
      $display("FAIL ack_vs_timeout: ok=%b done=%0d err=%0d, required 1/1/0", ok, done_cnt - d0, err_cnt - e0);
    end
  endtask

  task automatic test_forward_idle();
    exp_key.push_back(8'h1C); inject(8'h1C);
    exp_key.push_back(8'hFA); inject(8'hFA);
    exp_key.push_back(8'hFE); inject(8'hFE);
    n_cmp++;
    if (exp_key.size() != 0 || LED_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL forward_idle: keys_left=%0d busy=%b, required 0/0", exp_key.size(), LED_BUSY);
    end
  endtask

  task automatic test_reset_in_ack2();
    int t0, k, d0;
    bit ok;
    d0 = done_cnt; t0 = tx_cyc.size();
    exp_tx.push_back(8'hED); exp_tx.push_back(8'h05);
    plan.push_back(mk(1, 8'hFA, 8'h00, 1));
    plan.push_back(mk(0, 8'h00, 8'h00, 1));
    request(3'b101);
    k = 0;
    while (k < 300 && tx_cyc.size() - t0 < 2) begin @(negedge CLK); k++; end
    n_cmp++;
    if (k >= 300) begin n_bad++; $display("FAIL rst_ack2_reach: second byte not sent, required sent"); end
    cycles(10);
    RST_N = 1'b0;
    @(posedge CLK);
    #1;
    n_cmp++;
    if ({LED_BUSY, LED_DONE, LED_ERR, TX_START, TX_DATA, KEY_VALID, KEY_DATA} !== 21'h0) begin
      n_bad++;
      $display("FAIL rst_ack2_outputs: busy=%b done=%b err=%b txs=%b txd=%h kv=%b kd=%h, required all 0",
               LED_BUSY, LED_DONE, LED_ERR, TX_START, TX_DATA, KEY_VALID, KEY_DATA);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    cycles(2);
    exp_key.push_back(8'hFA);
    inject(8'hFA);
    wait_quiet(300, ok);
    n_cmp++;
    if (!ok || exp_key.size() != 0 || done_cnt - d0 != 0 || LED_BUSY !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_ack2_forward: ok=%b keys_left=%0d done=%0d busy=%b, required 1/0/0/0",
               ok, exp_key.size(), done_cnt - d0, LED_BUSY);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_resend();
    test_timeout();
    test_interleave();
    test_pending();
    test_retry_shared();
    test_ack_vs_timeout();
    test_forward_idle();
    test_reset_in_ack2();
    n_cmp++;
    if (exp_tx.size() != 0 || exp_key.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: tx_left=%0d keys_left=%0d, required 0/0", exp_tx.size(), exp_key.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
